// File: rtl/img_window_ctrl_pkg.sv
// Shared constants, scale encodings and update-FSM states
// for the image window controller.
package img_win_pkg;

   localparam int CW       = 10;
   localparam int IMG_W    = 32;
   localparam int IMG_H    = 32;
   localparam int PIPE_LAT = 3;

   typedef enum logic [1:0] {
      SCALE_1X  = 2'd0,
      SCALE_2X  = 2'd1,
      SCALE_4X  = 2'd2,
      SCALE_RSV = 2'd3
   } scale_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } upd_st_e;

   // Reserved encoding falls back to 1x.
   function automatic logic [1:0] scale_shift(input logic [1:0] sc);
      logic [1:0] sh;
      sh = 2'd0;
      case (scale_e'(sc))
         SCALE_2X: sh = 2'd1;
         SCALE_4X: sh = 2'd2;
         default:  sh = 2'd0;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/img_window_ctrl_if.sv
// Position/scale update handshake between a requester
// and the image window controller.
interface img_window_ctrl_if;
   import img_win_pkg::*;

   logic [CW-1:0] pos_x_new;
   logic [CW-1:0] pos_y_new;
   logic [1:0]    scale_new;
   logic          pos_valid;
   logic          pos_ready;

   modport master (
      output pos_x_new, pos_y_new, scale_new, pos_valid,
      input  pos_ready
   );

   modport slave (
      input  pos_x_new, pos_y_new, scale_new, pos_valid,
      output pos_ready
   );

endinterface

// File: rtl/img_window_ctrl_win_coord_map.sv
// Combinational screen-to-image coordinate mapping with
// window hit test; coordinates outside the window read as 0.
module win_coord_map
   import img_win_pkg::*;
#(
   parameter int WIDTH  = IMG_W,
   parameter int HEIGHT = IMG_H
) (
   input  logic [CW-1:0] x_px_i,
   input  logic [CW-1:0] y_px_i,
   input  logic [CW-1:0] pos_x_i,
   input  logic [CW-1:0] pos_y_i,
   input  logic [1:0]    scale_i,
   output logic [CW-1:0] x_img_o,
   output logic [CW-1:0] y_img_o,
   output logic          in_win_o
);

   logic signed [CW:0] dx;
   logic signed [CW:0] dy;
   logic [CW:0]        w_lim;
   logic [CW:0]        h_lim;
   logic [1:0]         sh;
   logic               in_x;
   logic               in_y;

   always_comb begin
      sh    = scale_shift(scale_i);
      dx    = $signed({1'b0, x_px_i}) - $signed({1'b0, pos_x_i});
      dy    = $signed({1'b0, y_px_i}) - $signed({1'b0, pos_y_i});
      w_lim = (CW+1)'(WIDTH) << sh;
      h_lim = (CW+1)'(HEIGHT) << sh;
      // Sign bit rejects pixels left of / above the window.
      in_x  = !dx[CW] && ($unsigned(dx) < w_lim);
      in_y  = !dy[CW] && ($unsigned(dy) < h_lim);
      in_win_o = in_x && in_y;
      x_img_o  = '0;
      y_img_o  = '0;
      if (in_win_o) begin
         x_img_o = CW'($unsigned(dx) >> sh);
         y_img_o = CW'($unsigned(dy) >> sh);
      end
   end

endmodule

// File: rtl/img_window_ctrl.sv
// Image window placement, ROM address sequencing, sync alignment
// and frame-synchronous position/scale updates.
module img_window_ctrl
   import img_win_pkg::*;
#(
   parameter int          WIDTH    = IMG_W,
   parameter int          HEIGHT   = IMG_H,
   parameter logic [CW-1:0] INIT_X = 10'd304,
   parameter logic [CW-1:0] INIT_Y = 10'd224,
   parameter logic [2:0]  BG_COLOR = 3'b000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [CW-1:0]   x_px,
   input  logic [CW-1:0]   y_px,
   input  logic            video_on,
   input  logic            hsync_in,
   input  logic            vsync_in,
   img_window_ctrl_if.slave upd,
   output logic [CW-1:0]   x_img,
   output logic [CW-1:0]   y_img,
   input  logic            Rp,
   input  logic            Gp,
   input  logic            Bp,
   output logic            red,
   output logic            green,
   output logic            blue,
   output logic            hsync_out,
   output logic            vsync_out,
   output logic            in_win
);

   upd_st_e       st_q, st_d;
   logic [CW-1:0] act_x_q, act_x_d;
   logic [CW-1:0] act_y_q, act_y_d;
   logic [1:0]    act_sc_q, act_sc_d;
   logic [CW-1:0] pnd_x_q, pnd_x_d;
   logic [CW-1:0] pnd_y_q, pnd_y_d;
   logic [1:0]    pnd_sc_q, pnd_sc_d;
   logic          boundary;
   logic          xfer;

   logic [CW-1:0] map_x, map_y;
   logic          map_win;

   logic [CW-1:0] x_img_q, y_img_q;
   logic          win1_q, vid1_q, hs1_q, vs1_q;
   logic          win2_q, vid2_q, hs2_q, vs2_q;
   logic          win3_q, hs3_q, vs3_q;
   logic [2:0]    rgb_q;

   win_coord_map #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_map (
      .x_px_i   (x_px),
      .y_px_i   (y_px),
      .pos_x_i  (act_x_q),
      .pos_y_i  (act_y_q),
      .scale_i  (act_sc_q),
      .x_img_o  (map_x),
      .y_img_o  (map_y),
      .in_win_o (map_win)
   );

   // vs1_q doubles as the previous vsync sample for edge detection.
   assign boundary      = vs1_q && !vsync_in;
   assign upd.pos_ready = (st_q == ST_IDLE);
   assign xfer          = upd.pos_valid && upd.pos_ready;

   always_comb begin
      st_d     = st_q;
      act_x_d  = act_x_q;
      act_y_d  = act_y_q;
      act_sc_d = act_sc_q;
      pnd_x_d  = pnd_x_q;
      pnd_y_d  = pnd_y_q;
      pnd_sc_d = pnd_sc_q;
      unique case (st_q)
         ST_IDLE: begin
            if (xfer) begin
               pnd_x_d  = upd.pos_x_new;
               pnd_y_d  = upd.pos_y_new;
               pnd_sc_d = upd.scale_new;
               st_d     = ST_PEND;
            end
         end
         ST_PEND: begin
            if (boundary) begin
               act_x_d  = pnd_x_q;
               act_y_d  = pnd_y_q;
               act_sc_d = pnd_sc_q;
               st_d     = ST_IDLE;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= ST_IDLE;
         act_x_q  <= INIT_X;
         act_y_q  <= INIT_Y;
         act_sc_q <= SCALE_1X;
         pnd_x_q  <= '0;
         pnd_y_q  <= '0;
         pnd_sc_q <= SCALE_1X;
      end else begin
         st_q     <= st_d;
         act_x_q  <= act_x_d;
         act_y_q  <= act_y_d;
         act_sc_q <= act_sc_d;
         pnd_x_q  <= pnd_x_d;
         pnd_y_q  <= pnd_y_d;
         pnd_sc_q <= pnd_sc_d;
      end
   end

   // Stage 1 issues the ROM address, stage 2 waits on the ROM.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_img_q <= '0;
         y_img_q <= '0;
         win1_q  <= 1'b0;
         vid1_q  <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         win2_q  <= 1'b0;
         vid2_q  <= 1'b0;
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
      end else begin
         x_img_q <= map_x;
         y_img_q <= map_y;
         win1_q  <= map_win;
         vid1_q  <= video_on;
         hs1_q   <= hsync_in;
         vs1_q   <= vsync_in;
         win2_q  <= win1_q;
         vid2_q  <= vid1_q;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q  <= 3'b000;
         win3_q <= 1'b0;
         hs3_q  <= 1'b1;
         vs3_q  <= 1'b1;
      end else begin
         win3_q <= win2_q;
         hs3_q  <= hs2_q;
         vs3_q  <= vs2_q;
         if (!vid2_q) begin
            rgb_q <= 3'b000;
         end else if (win2_q) begin
            rgb_q <= {Rp, Gp, Bp};
         end else begin
            rgb_q <= BG_COLOR;
         end
      end
   end

   assign x_img     = x_img_q;
   assign y_img     = y_img_q;
   assign red       = rgb_q[2];
   assign green     = rgb_q[1];
   assign blue      = rgb_q[0];
   assign hsync_out = hs3_q;
   assign vsync_out = vs3_q;
   assign in_win    = win3_q;

endmodule

// File: tb/tb_img_window_ctrl.sv
// Randomised and directed bench for img_window_ctrl against
// a frame-level reference model with a synchronous ROM stand-in.
module tb_img_window_ctrl;
   import img_win_pkg::*;

   localparam logic [2:0] BG = 3'b010;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] x_px, y_px;
   logic       video_on, hsync_in, vsync_in;
   logic [9:0] x_img, y_img;
   logic       Rp = 1'b0, Gp = 1'b0, Bp = 1'b0;
   logic       red, green, blue;
   logic       hsync_out, vsync_out, in_win;

   img_window_ctrl_if upd();

   img_window_ctrl #(
      .BG_COLOR (BG)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .x_px      (x_px),
      .y_px      (y_px),
      .video_on  (video_on),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .upd       (upd),
      .x_img     (x_img),
      .y_img     (y_img),
      .Rp        (Rp),
      .Gp        (Gp),
      .Bp        (Bp),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out),
      .in_win    (in_win)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] rom(input logic [9:0] x, y);
      int v;
      v = int'(x) * 5 + int'(y) * 3 + int'(x ^ y);
      return v[2:0];
   endfunction

   always @(posedge clk) {Rp, Gp, Bp} <= rom(x_img, y_img);

   typedef struct packed {
      logic [9:0] xi;
      logic [9:0] yi;
      logic       w;
      logic [2:0] c;
      logic       hs;
      logic       vs;
   } exp_t;

   exp_t q[$];
   int   ax, ay, asc, px, py, psc;
   bit   pend, pvs;
   int   checks, errors;

   bit         req_v;
   logic [9:0] req_x, req_y;
   logic [1:0] req_s;
   logic       vs_in, hs_in;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t idle();
      exp_t e;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      return e;
   endfunction

   task automatic reset_model();
      ax = 304; ay = 224; asc = 0;
      pend = 0; pvs = 1;
      q.delete();
      repeat (PIPE_LAT) q.push_back(idle());
   endtask

   function automatic exp_t predict(logic [9:0] x, y, logic vid, hs, vs);
      exp_t e;
      int s, dx, dy;
      s  = (asc == 1) ? 1 : (asc == 2) ? 2 : 0;
      dx = int'(x) - ax;
      dy = int'(y) - ay;
      e  = idle();
      e.w  = dx >= 0 && dx < (32 << s) && dy >= 0 && dy < (32 << s);
      e.hs = hs;
      e.vs = vs;
      if (e.w) begin
         e.xi = 10'(dx / (1 << s));
         e.yi = 10'(dy / (1 << s));
      end
      e.c = !vid ? 3'b000 : e.w ? rom(e.xi, e.yi) : BG;
      return e;
   endfunction

   task automatic step(logic r, logic [9:0] x, y, logic vid, hs, vs,
                       logic v, logic [9:0] nx, ny, logic [1:0] ns);
      bit bnd, rdy;
      chk("x_img", 32'(x_img), 32'(q[2].xi));
      chk("y_img", 32'(y_img), 32'(q[2].yi));
      chk("rgb", 32'({red, green, blue}), 32'(q[0].c));
      chk("in_win", 32'(in_win), 32'(q[0].w));
      chk("hsync", 32'(hsync_out), 32'(q[0].hs));
      chk("vsync", 32'(vsync_out), 32'(q[0].vs));
      chk("pos_ready", 32'(upd.pos_ready), 32'(!pend));
      void'(q.pop_front());
      rst = r;
      x_px = x; y_px = y;
      video_on = vid; hsync_in = hs; vsync_in = vs;
      upd.pos_valid = v;
      upd.pos_x_new = nx; upd.pos_y_new = ny; upd.scale_new = ns;
      if (r) begin
         reset_model();
      end else begin
         q.push_back(predict(x, y, vid, hs, vs));
         bnd = pvs && !vs;
         rdy = !pend;
         if (pend && bnd) begin
            ax = px; ay = py; asc = psc;
            pend = 0;
         end else if (v && rdy) begin
            px = int'(nx); py = int'(ny); psc = int'(ns);
            pend = 1;
         end
         pvs = vs;
      end
      @(negedge clk);
   endtask

   task automatic tick(logic [9:0] x, y, logic vid, logic r = 1'b0);
      bit acc;
      acc = req_v && !pend && !r;
      if ($urandom_range(0, 3) == 0) hs_in = ~hs_in;
      step(r, x, y, vid, hs_in, vs_in, req_v, req_x, req_y, req_s);
      if (acc || r) req_v = 0;
   endtask

   initial begin
      int fc, flen, span;
      logic [9:0] rx, ry;
      checks = 0; errors = 0;
      rst = 1; x_px = 0; y_px = 0;
      video_on = 0; hsync_in = 1; vsync_in = 1;
      upd.pos_valid = 0; upd.pos_x_new = 0;
      upd.pos_y_new = 0; upd.scale_new = 0;
      req_v = 0; req_x = 0; req_y = 0; req_s = 0;
      vs_in = 1; hs_in = 1;
      repeat (2) @(negedge clk);
      reset_model();

      // Default window edges at 1x
      tick(304, 224, 1); tick(303, 224, 1);
      tick(335, 224, 1); tick(336, 224, 1);
      tick(304, 255, 1); tick(304, 256, 1);
      tick(304, 223, 1); tick(310, 230, 0);
      repeat (3) tick(0, 0, 1);

      // Mid-frame request, then a stalled second request
      req_v = 1; req_x = 0; req_y = 0; req_s = 1;
      tick(304, 224, 1);
      tick(304, 224, 1);
      req_v = 1; req_x = 100; req_y = 50; req_s = 2;
      repeat (3) tick(310, 230, 1);
      vs_in = 0; tick(310, 230, 1); tick(0, 5, 1);
      vs_in = 1;
      for (int i = 0; i <= 64; i++) tick(10'(i), 5, 1);
      repeat (3) tick(0, 5, 1);
      vs_in = 0; tick(0, 0, 1); tick(0, 0, 1);
      vs_in = 1;
      for (int i = 0; i < 140; i += 7) tick(10'(96 + i), 10'(48 + i), 1);

      // Request coincident with the frame boundary
      req_v = 1; req_x = 400; req_y = 300; req_s = 0;
      vs_in = 0; tick(110, 60, 1);
      vs_in = 1; repeat (5) tick(110, 60, 1);
      tick(400, 300, 1);
      vs_in = 0; tick(400, 300, 1); tick(400, 300, 1);
      vs_in = 1;
      tick(400, 300, 1); tick(431, 331, 1); tick(432, 300, 1);
      tick(410, 310, 0); tick(399, 300, 1);
      repeat (3) tick(0, 0, 1);

      // Reset with an update pending
      req_v = 1; req_x = 1; req_y = 1; req_s = 1;
      tick(304, 224, 1); tick(304, 224, 1);
      tick(304, 224, 1, 1'b1);
      vs_in = 0; tick(304, 224, 1); tick(2, 2, 1);
      vs_in = 1; repeat (4) tick(304, 224, 1);
      tick(2, 2, 1);

      // Random frames, requests and occasional resets
      fc = 0; flen = 40;
      for (int i = 0; i < 3000; i++) begin
         if (fc == 0) flen = $urandom_range(20, 80);
         vs_in = (fc < 3) ? 1'b0 : 1'b1;
         fc = (fc + 1 == flen) ? 0 : fc + 1;
         if (!req_v && $urandom_range(0, 15) == 0) begin
            req_v = 1;
            req_x = 10'($urandom_range(0, 700));
            req_y = 10'($urandom_range(0, 500));
            req_s = 2'($urandom_range(0, 3));
         end
         span = 32 << ((asc == 1) ? 1 : (asc == 2) ? 2 : 0);
         if ($urandom_range(0, 3) == 0) begin
            rx = 10'($urandom); ry = 10'($urandom);
         end else begin
            rx = 10'(ax + int'($urandom_range(0, span + 8)) - 4);
            ry = 10'(ay + int'($urandom_range(0, span + 8)) - 4);
         end
         tick(rx, ry, $urandom_range(0, 7) != 0,
              $urandom_range(0, 499) == 0);
      end
      repeat (4) tick(0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
